// File: rtl/sgx_epc_ctrl.sv
// rtl/sgx_epc_ctrl.sv - multi-enclave EPC controller: slot lifecycle, EPCM ownership map, measurement
// and LSU access check; EDESTROY sweeps the EPCM one page per cycle.
module sgx_epc_ctrl #(
    parameter int NUM_ENCL = 4,
    parameter int PAGES    = 256,
    parameter int PAGE_LSB = 8,
    localparam int EID_W   = (NUM_ENCL > 1) ? $clog2(NUM_ENCL) : 1,
    localparam int PIDX_W  = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [EID_W-1:0] cmd_eid_i,
    input  logic [63:0]      cmd_addr_i,
    input  logic [63:0]      cmd_wdata_i,
    output logic             rsp_valid_o,
    output logic             rsp_err_o,
    output logic [2:0]       rsp_code_o,
    output logic [63:0]      rsp_data_o,
    input  logic             access_valid_i,
    input  logic [63:0]      access_addr_i,
    output logic             fault_o,
    output logic [1:0]       fault_cause_o,
    output logic             active_o,
    output logic [EID_W-1:0] active_eid_o
);
    typedef enum logic [1:0] {S_FREE = 2'd0, S_CREATED = 2'd1, S_INIT = 2'd2, S_RUN = 2'd3} slot_t;
    typedef enum logic {M_IDLE = 1'b0, M_SWEEP = 1'b1} mode_t;

    localparam logic [2:0] OP_ECREATE = 3'd0, OP_EADD = 3'd1, OP_EINIT = 3'd2,
                           OP_EENTER = 3'd3, OP_EEXIT = 3'd4, OP_EDESTROY = 3'd5;
    localparam logic [2:0] RC_OK = 3'd0, RC_BAD_STATE = 3'd1, RC_PAGE_BUSY = 3'd2,
                           RC_ILLEGAL = 3'd3, RC_CONFLICT = 3'd4;

    mode_t                         mode_q;
    slot_t [NUM_ENCL-1:0]          slot_q;
    logic  [NUM_ENCL-1:0][63:0]    meas_q;
    logic  [PAGES-1:0]             valid_q;
    logic  [PAGES-1:0][EID_W-1:0]  owner_q;
    logic  [PIDX_W-1:0]            sweep_idx_q;
    logic  [EID_W-1:0]             sweep_eid_q;
    logic                          active_q;
    logic  [EID_W-1:0]             active_eid_q;
    logic                          rsp_valid_q;
    logic  [2:0]                   rsp_code_q;
    logic  [63:0]                  rsp_data_q;
    logic  [2:0]                   code_d;

    logic [PIDX_W-1:0] cmd_pidx;
    logic [PIDX_W-1:0] acc_pidx;
    slot_t             cur_st;
    logic              cmd_fire;
    logic              page_busy;
    logic              acc_owned;
    logic              unused_bits;

    assign cmd_pidx    = cmd_addr_i[PAGE_LSB +: PIDX_W];
    assign acc_pidx    = access_addr_i[PAGE_LSB +: PIDX_W];
    assign cur_st      = slot_q[cmd_eid_i];
    assign cmd_fire    = cmd_valid_i && (mode_q == M_IDLE);
    assign page_busy   = valid_q[cmd_pidx];
    assign unused_bits = ^{cmd_addr_i, access_addr_i};

    // Only one slot can be RUN at a time, so active_q doubles as "some slot is running".
    always_comb begin
        code_d = RC_OK;
        case (cmd_op_i)
            OP_ECREATE:  if (cur_st != S_FREE) code_d = RC_BAD_STATE;
                         else if (page_busy)   code_d = RC_PAGE_BUSY;
            OP_EADD:     if (cur_st != S_CREATED) code_d = RC_BAD_STATE;
                         else if (page_busy)      code_d = RC_PAGE_BUSY;
            OP_EINIT:    if (cur_st != S_CREATED) code_d = RC_BAD_STATE;
            OP_EENTER:   if (cur_st != S_INIT)    code_d = RC_BAD_STATE;
                         else if (active_q)       code_d = RC_CONFLICT;
            OP_EEXIT:    if (cur_st != S_RUN)     code_d = RC_BAD_STATE;
            OP_EDESTROY: if (cur_st == S_RUN)     code_d = RC_BAD_STATE;
            default:     code_d = RC_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= M_IDLE;
            slot_q       <= {NUM_ENCL{S_FREE}};
            meas_q       <= '0;
            valid_q      <= '0;
            owner_q      <= '0;
            sweep_idx_q  <= '0;
            sweep_eid_q  <= '0;
            active_q     <= 1'b0;
            active_eid_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= RC_OK;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RC_OK;
            rsp_data_q  <= '0;
            case (mode_q)
                M_IDLE: if (cmd_fire) begin
                    rsp_valid_q <= 1'b1;
                    rsp_code_q  <= code_d;
                    if (code_d == RC_OK) begin
                        case (cmd_op_i)
                            OP_ECREATE: begin
                                valid_q[cmd_pidx]  <= 1'b1;
                                owner_q[cmd_pidx]  <= cmd_eid_i;
                                meas_q[cmd_eid_i]  <= 64'(cmd_pidx);
                                slot_q[cmd_eid_i]  <= S_CREATED;
                            end
                            OP_EADD: begin
                                valid_q[cmd_pidx]  <= 1'b1;
                                owner_q[cmd_pidx]  <= cmd_eid_i;
                                meas_q[cmd_eid_i]  <= {meas_q[cmd_eid_i][62:0], meas_q[cmd_eid_i][63]}
                                                      ^ cmd_wdata_i ^ 64'(cmd_pidx);
                            end
                            OP_EINIT: begin
                                slot_q[cmd_eid_i]  <= S_INIT;
                                rsp_data_q         <= meas_q[cmd_eid_i];
                            end
                            OP_EENTER: begin
                                slot_q[cmd_eid_i]  <= S_RUN;
                                active_q           <= 1'b1;
                                active_eid_q       <= cmd_eid_i;
                            end
                            OP_EEXIT: begin
                                slot_q[cmd_eid_i]  <= S_INIT;
                                active_q           <= 1'b0;
                                active_eid_q       <= '0;
                            end
                            OP_EDESTROY: if (cur_st != S_FREE) begin
                                // Response is deferred until the sweep has visited every page.
                                rsp_valid_q        <= 1'b0;
                                mode_q             <= M_SWEEP;
                                sweep_idx_q        <= '0;
                                sweep_eid_q        <= cmd_eid_i;
                            end
                            default: ;
                        endcase
                    end
                end
                M_SWEEP: begin
                    if (valid_q[sweep_idx_q] && (owner_q[sweep_idx_q] == sweep_eid_q)) begin
                        valid_q[sweep_idx_q] <= 1'b0;
                        owner_q[sweep_idx_q] <= '0;
                    end
                    if (sweep_idx_q == PIDX_W'(PAGES - 1)) begin
                        mode_q              <= M_IDLE;
                        slot_q[sweep_eid_q] <= S_FREE;
                        meas_q[sweep_eid_q] <= '0;
                        rsp_valid_q         <= 1'b1;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + 1'b1;
                    end
                end
                default: mode_q <= M_IDLE;
            endcase
        end
    end

    assign acc_owned     = valid_q[acc_pidx] && (owner_q[acc_pidx] == active_eid_q);
    assign fault_o       = access_valid_i && active_q && !acc_owned;
    assign fault_cause_o = !fault_o ? 2'd0 : (!valid_q[acc_pidx] ? 2'd1 : 2'd2);

    assign cmd_ready_o   = (mode_q == M_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_code_o    = rsp_code_q;
    assign rsp_err_o     = (rsp_code_q != RC_OK);
    assign rsp_data_o    = rsp_data_q;
    assign active_o      = active_q;
    assign active_eid_o  = active_eid_q;
endmodule

// File: tb/tb_sgx_epc_ctrl.sv
// tb/tb_sgx_epc_ctrl.sv - scoreboard bench for sgx_epc_ctrl: lifecycle, access check, sweep, reset abort.
module tb_sgx_epc_ctrl;
    localparam logic [2:0] ECREATE = 3'd0, EADD = 3'd1, EINIT = 3'd2, EENTER = 3'd3,
                           EEXIT = 3'd4, EDESTROY = 3'd5;
    localparam logic [2:0] OK = 3'd0, BAD = 3'd1, BUSY = 3'd2, ILL = 3'd3, CONF = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_eid = '0;
    logic [63:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [2:0]  rsp_code;
    logic [63:0] rsp_data;
    logic        access_valid = 1'b0;
    logic [63:0] access_addr = '0;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        active;
    logic [1:0]  active_eid;

    typedef struct packed {
        logic [2:0]  code;
        logic [63:0] data;
    } exp_t;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    sgx_epc_ctrl #(.NUM_ENCL(4), .PAGES(256), .PAGE_LSB(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_eid_i(cmd_eid), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_code_o(rsp_code), .rsp_data_o(rsp_data),
        .access_valid_i(access_valid), .access_addr_i(access_addr),
        .fault_o(fault), .fault_cause_o(fault_cause),
        .active_o(active), .active_eid_o(active_eid)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got code=%0d data=%h, required no response", rsp_code, rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_code !== e.code || rsp_err !== (e.code != 3'd0) || rsp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rsp: got code=%0d err=%0b data=%h, required code=%0d err=%0b data=%h",
                                 rsp_code, rsp_err, rsp_data, e.code, (e.code != 3'd0), e.data);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] eid, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [2:0] ecode, input logic [63:0] edata,
                            input bit expect_rsp);
        int t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got %b, required 1", cmd_ready);
        end
        if (expect_rsp) sb_q.push_back('{code: ecode, data: edata});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_eid   = eid;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic probe(input string name, input logic v, input logic [63:0] addr,
                         input logic ef, input logic [1:0] ec);
        access_valid = v;
        access_addr  = addr;
        #1;
        n_checks++;
        if (fault !== ef || fault_cause !== ec) begin
            n_fail++;
            $display("FAIL %s: got fault=%b cause=%0d, required fault=%b cause=%0d", name, fault, fault_cause, ef, ec);
        end
        access_valid = 1'b0;
    endtask

    task automatic check_active(input string name, input logic ea, input logic [1:0] ee);
        n_checks++;
        if (active !== ea || active_eid !== ee) begin
            n_fail++;
            $display("FAIL %s: got active=%b eid=%0d, required active=%b eid=%0d", name, active, active_eid, ea, ee);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_code !== 3'd0 || rsp_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b rsp_valid=%b code=%0d, required 1 0 0", cmd_ready, rsp_valid, rsp_code);
        end
        check_active("reset_active", 1'b0, 2'd0);
        probe("reset_probe", 1'b1, 64'h100, 1'b0, 2'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_lifecycle();
        send_cmd(ECREATE, 2'd0, 64'h100, 64'd0, OK, 64'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_n1: got rsp_valid=%b ready=%b, required 1 1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: got rsp_valid=%b in N+2, required 0", rsp_valid);
        end
        send_cmd(EADD,  2'd0, 64'h200, 64'hA5, OK, 64'd0, 1'b1);
        send_cmd(EINIT, 2'd0, 64'h0, 64'h0, OK, 64'hA5, 1'b1);
        send_cmd(EADD,  2'd0, 64'h300, 64'h1, BAD, 64'd0, 1'b1);
        wait_drain();
    endtask

    task automatic test_access();
        probe("probe_inactive", 1'b1, 64'h0200, 1'b0, 2'd0);
        probe("probe_inactive_unowned", 1'b1, 64'h0900, 1'b0, 2'd0);
        send_cmd(EENTER, 2'd0, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        #1 check_active("enter_e0", 1'b1, 2'd0);
        wait_drain();
        probe("probe_owned", 1'b1, 64'h200, 1'b0, 2'd0);
        probe("probe_unowned", 1'b1, 64'h300, 1'b1, 2'd1);
        probe("probe_wrap", 1'b1, 64'hFFFF_0000_0001_0200, 1'b0, 2'd0);
        probe("probe_no_valid", 1'b0, 64'h300, 1'b0, 2'd0);
    endtask

    task automatic test_conflict();
        send_cmd(ECREATE, 2'd1, 64'h200, 64'h0, BUSY, 64'd0, 1'b1);
        send_cmd(ECREATE, 2'd1, 64'h400, 64'h0, OK, 64'd0, 1'b1);
        wait_drain();
        probe("probe_other_owner", 1'b1, 64'h400, 1'b1, 2'd2);
        send_cmd(EINIT,  2'd1, 64'h0, 64'h0, OK, 64'h4, 1'b1);
        send_cmd(EENTER, 2'd1, 64'h0, 64'h0, CONF, 64'd0, 1'b1);
        send_cmd(EENTER, 2'd0, 64'h0, 64'h0, BAD, 64'd0, 1'b1);
        wait_drain();
        check_active("conflict_keeps_e0", 1'b1, 2'd0);
    endtask

    task automatic test_destroy();
        int low = 0;
        send_cmd(EDESTROY, 2'd0, 64'h0, 64'h0, BAD, 64'd0, 1'b1);
        send_cmd(EEXIT,    2'd0, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        wait_drain();
        check_active("exit_e0", 1'b0, 2'd0);
        send_cmd(EDESTROY, 2'd0, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        forever begin
            @(negedge clk);
            if (cmd_ready === 1'b1 || low >= 1000) break;
            low++;
        end
        n_checks++;
        if (low != 256 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_len: got ready low %0d cycles rsp_valid=%b at return, required 256 and 1", low, rsp_valid);
        end
        wait_drain();
        send_cmd(EDESTROY, 2'd0, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL destroy_free: got ready=%b rsp_valid=%b, required 1 1", cmd_ready, rsp_valid);
        end
        send_cmd(ECREATE, 2'd2, 64'h100, 64'h0, OK, 64'd0, 1'b1);
        send_cmd(EADD,    2'd2, 64'h200, 64'h0, OK, 64'd0, 1'b1);
        send_cmd(ECREATE, 2'd3, 64'h400, 64'h0, BUSY, 64'd0, 1'b1);
        send_cmd(EINIT,   2'd0, 64'h0, 64'h0, BAD, 64'd0, 1'b1);
        send_cmd(EENTER,  2'd1, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        wait_drain();
        check_active("enter_e1", 1'b1, 2'd1);
        probe("e1_own_page", 1'b1, 64'h400, 1'b0, 2'd0);
        probe("e1_sees_e2_page", 1'b1, 64'h100, 1'b1, 2'd2);
        send_cmd(EEXIT, 2'd1, 64'h0, 64'h0, OK, 64'd0, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_midsweep();
        send_cmd(EDESTROY, 2'd2, 64'h0, 64'h0, OK, 64'd0, 1'b0);
        repeat (100) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_busy: got ready=%b at sweep cycle 100, required 0", cmd_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got ready=%b rsp_valid=%b active=%b, required 1 0 0", cmd_ready, rsp_valid, active);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        send_cmd(ECREATE, 2'd1, 64'h400, 64'h0, OK, 64'd0, 1'b1);
        send_cmd(ECREATE, 2'd2, 64'h100, 64'h0, OK, 64'd0, 1'b1);
        send_cmd(3'd7,    2'd1, 64'h800, 64'h0, ILL, 64'd0, 1'b1);
        send_cmd(3'd6,    2'd3, 64'h800, 64'h0, ILL, 64'd0, 1'b1);
        send_cmd(ECREATE, 2'd1, 64'h800, 64'h0, BAD, 64'd0, 1'b1);
        send_cmd(ECREATE, 2'd3, 64'h800, 64'h0, OK, 64'd0, 1'b1);
        send_cmd(EINIT,   2'd1, 64'h0, 64'h0, OK, 64'h4, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_lifecycle();
        test_access();
        test_conflict();
        test_destroy();
        test_reset_midsweep();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
